bus_reg_file: RTL

// - Receiving end of the shifter output bus: captures the 8-bit result and carry from the shift/rotate stage

---
 rtl/bus_reg_file.sv | 77 +++++++
 1 files changed

// File: rtl/bus_reg_file.sv
// bus_reg_file: captures the shifter bus result/carry into NREG registers plus CF/ZF, with two
// combinational ALU read ports. Define BUS_REG_BYPASS_EN for same-cycle write-through forwarding.
module bus_reg_file #(
  parameter int DW = 8,
  parameter int NREG = 4,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] bus_in,
  input  logic          cf_in,
  input  logic          bus_vld,
  input  logic          ld_en,
  input  logic          flag_ld,
  input  logic [AW-1:0] wr_sel,
  input  logic [AW-1:0] rd_a_sel,
  input  logic [AW-1:0] rd_b_sel,
  input  logic          err_clr,
  output logic [DW-1:0] rd_a,
  output logic [DW-1:0] rd_b,
  output logic          cf_out,
  output logic          zf_out,
  output logic          wr_ack,
  output logic          err
);

  // Handshake: bus_vld is the valid qualifier of bus_in/cf_in and there is no ready; a load or
  // flag request with bus_vld=1 is always accepted at the edge, without it the request is dropped
  // (bus_in never sampled) and the sticky err is raised.
  logic [DW-1:0] regs [NREG];
  logic          wr_go;
  logic          flag_go;
  logic          reject;

  assign wr_go   = ld_en & bus_vld;
  assign flag_go = flag_ld & bus_vld;
  assign reject  = (ld_en | flag_ld) & ~bus_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      wr_ack <= 1'b0;
    end else begin
      if (wr_go) regs[wr_sel] <= bus_in;
      wr_ack <= wr_go;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cf_out <= 1'b0;
      zf_out <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (flag_go) begin
        cf_out <= cf_in;
        zf_out <= (bus_in == '0);
      end
      // A rejected op in the same cycle as err_clr keeps err set.
      if (reject)       err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

`ifdef BUS_REG_BYPASS_EN
  always_comb begin
    rd_a = regs[rd_a_sel];
    rd_b = regs[rd_b_sel];
    if (wr_go && (rd_a_sel == wr_sel)) rd_a = bus_in;
    if (wr_go && (rd_b_sel == wr_sel)) rd_b = bus_in;
  end
`else
  assign rd_a = regs[rd_a_sel];
  assign rd_b = regs[rd_b_sel];
`endif

endmodule
